// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, CPOL edge patterns and bit-order helpers.
// Imported by both the SPI master and the SPI slave so that the two ends agree on edges and ordering.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEAD = 3'd1,
        ST_XFER = 3'd2,
        ST_TAIL = 3'd3,
        ST_GAP  = 3'd4
    } spi_state_t;

    // {sclk before, sclk after} of the data-sampling (leading) edge for each CPOL
    localparam logic [1:0] LEAD_EDGE_CPOL0 = 2'b01;
    localparam logic [1:0] LEAD_EDGE_CPOL1 = 2'b10;

    // Depth of the MISO synchroniser; the sample point trails the SCLK edge by this many cycles
    localparam int SYNC_STAGES = 2;

    function automatic logic is_lead_edge(input logic cpol, input logic sclk_now, input logic sclk_next);
        logic [1:0] pat;
        pat = cpol ? LEAD_EDGE_CPOL1 : LEAD_EDGE_CPOL0;
        return {sclk_now, sclk_next} == pat;
    endfunction

    // Frames go MSB-first: the first bit on the wire is bit N-1
    function automatic int unsigned first_bit_index(input int unsigned n);
        return n - 1;
    endfunction

endpackage

// File: rtl/spi_master_if.sv
// Request/response and SPI pin bundle for spi_master.
// The master modport is the spi_master view; the slave modport is the requester / SPI peer side.
interface spi_master_if #(
    parameter int p_data_buffer_length  = 32,
    parameter int p_width_buffer_length = $clog2(p_data_buffer_length) + 1
);
    logic                             i_start;
    logic [p_data_buffer_length-1:0]  ip_data_out;
    logic [p_width_buffer_length-1:0] ip_data_count;
    logic [p_data_buffer_length-1:0]  op_data_in;
    logic                             o_data_valid;
    logic                             o_busy;
    logic                             o_error;
    logic                             o_sclk;
    logic                             o_mosi;
    logic                             i_miso;
    logic                             o_cs_n;

    modport master (
        input  i_start, ip_data_out, ip_data_count, i_miso,
        output op_data_in, o_data_valid, o_busy, o_error, o_sclk, o_mosi, o_cs_n
    );

    modport slave (
        output i_start, ip_data_out, ip_data_count, i_miso,
        input  op_data_in, o_data_valid, o_busy, o_error, o_sclk, o_mosi, o_cs_n
    );
endinterface

// File: rtl/spi_clk_gen.sv
// SCLK generator: half-period divider, toggle register and leading/trailing edge strobes.
// The strobes are high in the cycle whose closing clk edge toggles SCLK, so the master can act on that same edge.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int p_clk_div   = 4,
    parameter bit p_cpol      = 1'b0,
    parameter int p_tog_width = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic                   sclk,
    output logic                   lead_edge,
    output logic                   trail_edge,
    output logic [p_tog_width-1:0] toggle_cnt
);
    localparam int CNT_W = $clog2(p_clk_div);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(p_clk_div - 1);

    logic [CNT_W-1:0] div_cnt_reg;
    logic             tick;

    // First toggle happens on the first enabled cycle, then every p_clk_div cycles
    assign tick       = en && (div_cnt_reg == '0);
    assign lead_edge  = tick &&  is_lead_edge(p_cpol, sclk, ~sclk);
    assign trail_edge = tick && !is_lead_edge(p_cpol, sclk, ~sclk);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_reg <= '0;
            sclk        <= p_cpol;
            toggle_cnt  <= '0;
        end else if (!en) begin
            div_cnt_reg <= '0;
            sclk        <= p_cpol;
            toggle_cnt  <= '0;
        end else begin
            div_cnt_reg <= (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + CNT_W'(1);
            if (tick) begin
                sclk       <= ~sclk;
                toggle_cnt <= toggle_cnt + p_tog_width'(1);
            end
        end
    end
endmodule

// File: rtl/spi_master.sv
// SPI master: one full-duplex frame of 1..p_data_buffer_length bits per accepted start, MSB-first.
// Owns the frame FSM, the shift index and the MISO synchroniser; SCLK timing comes from spi_clk_gen.
module spi_master
    import spi_pkg::*;
#(
    parameter int p_data_buffer_length  = 32,
    parameter int p_width_buffer_length = $clog2(p_data_buffer_length) + 1,
    parameter int p_clk_div             = 4,
    parameter int p_gap_cycles          = 2,
    parameter bit p_cpol                = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    spi_master_if.master  bus
);
    localparam int DL    = p_data_buffer_length;
    localparam int WL    = p_width_buffer_length;
    localparam int BIT_W = $clog2(p_data_buffer_length);
    localparam int TOG_W = p_width_buffer_length + 1;
    localparam int CNT_W = 16;

    localparam logic [WL-1:0]    MAX_N     = WL'(p_data_buffer_length);
    localparam logic [CNT_W-1:0] LEAD_LOAD = CNT_W'(p_clk_div - 2);
    localparam logic [CNT_W-1:0] TAIL_LOAD = CNT_W'(p_clk_div - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = (p_gap_cycles > 0) ? CNT_W'(p_gap_cycles - 1) : '0;

    spi_state_t             state_reg;
    logic [DL-1:0]          data_reg;
    logic [DL-1:0]          rx_reg;
    logic [WL-1:0]          count_reg;
    logic [BIT_W-1:0]       idx_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   cs_n_reg;
    logic                   mosi_reg;
    logic                   busy_reg;
    logic                   valid_reg;
    logic                   error_reg;
    logic [SYNC_STAGES-1:0] miso_sync_reg;
    logic [SYNC_STAGES-1:0] lead_dly_reg;

    logic                   sclk;
    logic                   lead_edge;
    logic                   trail_edge;
    logic [TOG_W-1:0]       toggle_cnt;
    logic                   start_legal;
    logic                   last_toggle;
    logic [BIT_W-1:0]       start_idx;
    logic [BIT_W-1:0]       next_idx;

    spi_clk_gen #(
        .p_clk_div   (p_clk_div),
        .p_cpol      (p_cpol),
        .p_tog_width (TOG_W)
    ) u_clk_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (state_reg == ST_XFER),
        .sclk       (sclk),
        .lead_edge  (lead_edge),
        .trail_edge (trail_edge),
        .toggle_cnt (toggle_cnt)
    );

    assign start_legal = (bus.ip_data_count != '0) && (bus.ip_data_count <= MAX_N);
    assign start_idx   = BIT_W'(first_bit_index(32'(bus.ip_data_count)));
    assign next_idx    = idx_reg - BIT_W'(1);
    // The 2N-th toggle is always a trailing edge back to the idle level
    assign last_toggle = trail_edge && (toggle_cnt == ({count_reg, 1'b0} - TOG_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            data_reg      <= '0;
            rx_reg        <= '0;
            count_reg     <= '0;
            idx_reg       <= '0;
            cnt_reg       <= '0;
            cs_n_reg      <= 1'b1;
            mosi_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            valid_reg     <= 1'b0;
            error_reg     <= 1'b0;
            miso_sync_reg <= '0;
            lead_dly_reg  <= '0;
        end else begin
            valid_reg     <= 1'b0;
            error_reg     <= 1'b0;
            miso_sync_reg <= {miso_sync_reg[SYNC_STAGES-2:0], bus.i_miso};
            lead_dly_reg  <= {lead_dly_reg[SYNC_STAGES-2:0], lead_edge};

            // Capture lands SYNC_STAGES cycles after the leading edge, never later than the trailing edge
            if (lead_dly_reg[SYNC_STAGES-1]) begin
                rx_reg[idx_reg] <= miso_sync_reg[SYNC_STAGES-1];
            end

            case (state_reg)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        if (start_legal) begin
                            data_reg  <= bus.ip_data_out;
                            count_reg <= bus.ip_data_count;
                            idx_reg   <= start_idx;
                            rx_reg    <= '0;
                            mosi_reg  <= bus.ip_data_out[start_idx];
                            cs_n_reg  <= 1'b0;
                            busy_reg  <= 1'b1;
                            cnt_reg   <= LEAD_LOAD;
                            state_reg <= ST_LEAD;
                        end else begin
                            error_reg <= 1'b1;
                        end
                    end
                end

                ST_LEAD: begin
                    if (cnt_reg == '0) begin
                        state_reg <= ST_XFER;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end

                ST_XFER: begin
                    if (trail_edge && (idx_reg != '0)) begin
                        idx_reg  <= next_idx;
                        mosi_reg <= data_reg[next_idx];
                    end
                    if (last_toggle) begin
                        cnt_reg   <= TAIL_LOAD;
                        state_reg <= ST_TAIL;
                    end
                end

                ST_TAIL: begin
                    if (cnt_reg == '0) begin
                        cs_n_reg  <= 1'b1;
                        valid_reg <= 1'b1;
                        if (p_gap_cycles == 0) begin
                            busy_reg  <= 1'b0;
                            state_reg <= ST_IDLE;
                        end else begin
                            cnt_reg   <= GAP_LOAD;
                            state_reg <= ST_GAP;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end

                ST_GAP: begin
                    if (cnt_reg == '0) begin
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.op_data_in   = rx_reg;
    assign bus.o_data_valid = valid_reg;
    assign bus.o_busy       = busy_reg;
    assign bus.o_error      = error_reg;
    assign bus.o_sclk       = sclk;
    assign bus.o_mosi       = mosi_reg;
    assign bus.o_cs_n       = cs_n_reg;
endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: instance A (D=2, CPOL=0, gap=2) in MOSI->MISO loopback,
// instance B (D=3, CPOL=1, gap=0) against a behavioural SPI slave model.
module tb_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    int   cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    spi_master_if #(.p_data_buffer_length(32)) ifa ();
    spi_master_if #(.p_data_buffer_length(32)) ifb ();

    spi_master #(.p_data_buffer_length(32), .p_clk_div(2), .p_gap_cycles(2), .p_cpol(1'b0))
        dut_a (.clk(clk), .rst_n(rst_a), .bus(ifa));
    spi_master #(.p_data_buffer_length(32), .p_clk_div(3), .p_gap_cycles(0), .p_cpol(1'b1))
        dut_b (.clk(clk), .rst_n(rst_b), .bus(ifb));

    assign ifa.i_miso = ifa.o_mosi;

    // Behavioural slave on B: shifts out on the trailing (rising) edge, samples on the leading (falling) edge
    logic [31:0] slv_tx = 32'h12345678;
    logic [31:0] slv_rx = 32'h0;
    int          slv_k  = 0;
    assign ifb.i_miso = slv_tx[5'(31 - slv_k)];
    always @(posedge ifb.o_cs_n or posedge ifb.o_sclk) begin
        if (ifb.o_cs_n) slv_k <= 0;
        else if (slv_k < 31) slv_k <= slv_k + 1;
    end
    always @(negedge ifb.o_sclk) begin
        if (!ifb.o_cs_n) slv_rx <= {slv_rx[30:0], ifb.o_mosi};
    end

    typedef struct {
        logic [31:0] data;
        int          cyc;
        int          tog;
        logic [31:0] slv;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];
    exp_t ea, eb;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    // Monitors: pop the expected frame whenever a valid pulse appears
    int   tog_a = 0, tog_b = 0, err_a = 0;
    logic sclk_prev_a = 1'b0, sclk_prev_b = 1'b1;

    always @(negedge clk) begin
        if (!rst_a) begin
            tog_a = 0;
            sclk_prev_a = ifa.o_sclk;
        end else begin
            if (ifa.o_sclk !== sclk_prev_a) tog_a++;
            sclk_prev_a = ifa.o_sclk;
            if (ifa.o_error) err_a++;
            if (ifa.o_data_valid) begin
                if (sb_a.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL a_unexpected_valid: got valid with %h at cycle %0d, required none", ifa.op_data_in, cyc);
                end else begin
                    ea = sb_a.pop_front();
                    chk("a_rx_word", ifa.op_data_in, ea.data);
                    chk("a_valid_cycle", cyc, ea.cyc);
                    chk("a_sclk_toggles", tog_a, ea.tog);
                    chk("a_cs_n_at_valid", {31'b0, ifa.o_cs_n}, 32'd1);
                end
                tog_a = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_b) begin
            tog_b = 0;
            sclk_prev_b = ifb.o_sclk;
        end else begin
            if (ifb.o_sclk !== sclk_prev_b) tog_b++;
            sclk_prev_b = ifb.o_sclk;
            if (ifb.o_data_valid) begin
                if (sb_b.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL b_unexpected_valid: got valid with %h at cycle %0d, required none", ifb.op_data_in, cyc);
                end else begin
                    eb = sb_b.pop_front();
                    chk("b_master_rx", ifb.op_data_in, eb.data);
                    chk("b_slave_rx", slv_rx, eb.slv);
                    chk("b_valid_cycle", cyc, eb.cyc);
                    chk("b_sclk_toggles", tog_b, eb.tog);
                    chk("b_sclk_idle_high", {31'b0, ifb.o_sclk}, 32'd1);
                end
                tog_b = 0;
            end
        end
    end

    task automatic start_a(input logic [31:0] d, input logic [5:0] n, input logic [31:0] exp_rx,
                           input int lat, input bit push, input bit hold);
        @(posedge clk); #1;
        ifa.ip_data_out   = d;
        ifa.ip_data_count = n;
        ifa.i_start       = 1'b1;
        if (push) sb_a.push_back('{exp_rx, cyc + lat, 2 * int'(n), 32'h0});
        if (!hold) begin
            @(posedge clk); #1;
            ifa.i_start = 1'b0;
        end
    endtask

    task automatic wait_valid(input int inst, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((inst == 0) ? ifa.o_data_valid : ifb.o_data_valid) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout_valid_%0d: no valid within %0d cycles, required one", inst, budget);
        end
    endtask

    task automatic wait_idle(input int inst, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!((inst == 0) ? ifa.o_busy : ifb.o_busy)) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout_idle_%0d: busy still 1 after %0d cycles, required 0", inst, budget);
        end
    endtask

    task automatic err_test(input logic [5:0] n, input string tag);
        @(posedge clk); #1;
        ifa.ip_data_count = n;
        ifa.i_start       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_error_pulse"}, {31'b0, ifa.o_error}, 32'd1);
        chk({tag, "_busy_low"}, {31'b0, ifa.o_busy}, 32'd0);
        chk({tag, "_cs_n_high"}, {31'b0, ifa.o_cs_n}, 32'd1);
        ifa.i_start = 1'b0;
        @(negedge clk);
        chk({tag, "_error_one_cycle"}, {31'b0, ifa.o_error}, 32'd0);
        chk({tag, "_busy_still_low"}, {31'b0, ifa.o_busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog expired");
    end

    int v1, f1, at, tmo;

    initial begin
        ifa.i_start = 1'b0; ifa.ip_data_out = '0; ifa.ip_data_count = '0;
        ifb.i_start = 1'b0; ifb.ip_data_out = '0; ifb.ip_data_count = '0;
        repeat (3) @(negedge clk);

        // Reset state of both instances
        chk("rst_a_sclk",  {31'b0, ifa.o_sclk}, 32'd0);
        chk("rst_b_sclk",  {31'b0, ifb.o_sclk}, 32'd1);
        chk("rst_a_cs_n",  {31'b0, ifa.o_cs_n}, 32'd1);
        chk("rst_b_cs_n",  {31'b0, ifb.o_cs_n}, 32'd1);
        chk("rst_a_mosi",  {31'b0, ifa.o_mosi}, 32'd0);
        chk("rst_a_busy",  {31'b0, ifa.o_busy}, 32'd0);
        chk("rst_a_valid", {31'b0, ifa.o_data_valid}, 32'd0);
        chk("rst_a_error", {31'b0, ifa.o_error}, 32'd0);
        chk("rst_a_rx",    ifa.op_data_in, 32'h0);
        rst_a = 1'b1;
        rst_b = 1'b1;

        // Loopback N=8 with an ignored start pulse mid-frame
        start_a(32'h000000A5, 6'd8, 32'h000000A5, 35, 1'b1, 1'b0);
        repeat (8) @(posedge clk);
        #1 ifa.ip_data_count = 6'd0; ifa.i_start = 1'b1;
        @(posedge clk); #1 ifa.i_start = 1'b0;
        wait_valid(0, 100, at);
        wait_idle(0, 20);
        chk("a_busy_start_no_error", err_a, 32'd0);

        // N=1 boundary
        start_a(32'h00000001, 6'd1, 32'h00000001, 7, 1'b1, 1'b0);
        wait_valid(0, 50, at);
        wait_idle(0, 20);

        // Illegal lengths
        err_test(6'd0, "n0");
        err_test(6'd33, "n33");
        chk("a_error_count", err_a, 32'd2);

        // Back-to-back with start held high
        start_a(32'h0000005A, 6'd8, 32'h0000005A, 35, 1'b1, 1'b1);
        sb_a.push_back('{32'h0000005A, cyc + 72, 16, 32'h0});
        wait_valid(0, 100, v1);
        f1 = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!ifa.o_cs_n) begin
                f1 = cyc;
                break;
            end
        end
        chk("b2b_cs_fall_after_valid", f1 - v1, 32'd3);
        ifa.i_start = 1'b0;
        wait_valid(0, 100, at);
        wait_idle(0, 20);

        // Reset in the middle of a frame
        start_a(32'h0000C3C3, 6'd16, 32'h0, 0, 1'b0, 1'b0);
        tmo = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tog_a >= 5) begin
                tmo = 0;
                break;
            end
        end
        chk("mid_reset_reached_5_toggles", tmo, 32'd0);
        #1 rst_a = 1'b0;
        #1;
        chk("mid_reset_cs_n",  {31'b0, ifa.o_cs_n}, 32'd1);
        chk("mid_reset_sclk",  {31'b0, ifa.o_sclk}, 32'd0);
        chk("mid_reset_busy",  {31'b0, ifa.o_busy}, 32'd0);
        chk("mid_reset_valid", {31'b0, ifa.o_data_valid}, 32'd0);
        chk("mid_reset_rx",    ifa.op_data_in, 32'h0);
        repeat (3) @(negedge clk);
        rst_a = 1'b1;
        start_a(32'hFFFFFF3C, 6'd6, 32'h0000003C, 27, 1'b1, 1'b0);
        wait_valid(0, 100, at);
        wait_idle(0, 20);

        // Instance B: CPOL=1, N=32 against the slave model
        @(posedge clk); #1;
        ifb.ip_data_out   = 32'hDEADBEEF;
        ifb.ip_data_count = 6'd32;
        ifb.i_start       = 1'b1;
        sb_b.push_back('{32'h12345678, cyc + 196, 64, 32'hDEADBEEF});
        @(posedge clk); #1 ifb.i_start = 1'b0;
        wait_valid(1, 300, at);
        wait_idle(1, 20);

        repeat (5) @(negedge clk);
        chk("sb_a_drained", sb_a.size(), 32'd0);
        chk("sb_b_drained", sb_b.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
